// File: rtl/smart_flit_sink_if.sv
// Local-port flit/credit link between the NoC ejection side and the sink,
// plus the valid/ready stream from the sink to the tile consumer.
interface smart_flit_sink_if #(
    parameter int FLIT_WIDTH = 33
);
    logic                  flit_in_valid;
    logic [FLIT_WIDTH-1:0] flit_in;
    logic                  credit_out;
    logic                  flit_out_valid;
    logic [FLIT_WIDTH-1:0] flit_out;
    logic                  flit_out_ready;

    modport master (
        output flit_in_valid,
        output flit_in,
        input  credit_out,
        input  flit_out_valid,
        input  flit_out,
        output flit_out_ready
    );

    modport slave (
        input  flit_in_valid,
        input  flit_in,
        output credit_out,
        input  flit_out_ready,
        output flit_out_valid,
        output flit_out
    );
endinterface

// File: rtl/smart_flit_sink.sv
// SMART NoC ejection endpoint: credit-managed flit buffer with parity
// checking, run accounting against an expected flit count, and consumer stream.
module smart_flit_sink #(
    parameter int FLIT_WIDTH     = 33,
    parameter int DEPTH          = 4,
    parameter int PERR_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [30:0]               expected_num_flits,
    smart_flit_sink_if.slave          flit_if,
    output logic [30:0]               rx_count,
    output logic [PERR_CNT_WIDTH-1:0] parity_err_count,
    output logic                      overflow_err,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;
    logic [1:0]            state;
    logic                  credit_q;

    logic        not_empty;
    logic        full;
    logic        deq;
    logic        enq;
    logic        drop;
    logic        bad;
    logic        cnt_en;
    logic        hit;
    logic [30:0] rx_next;
    logic [PERR_CNT_WIDTH-1:0] perr_next;

    assign not_empty = (occ != '0);
    assign full      = (occ == (AW+1)'(DEPTH));
    assign deq       = not_empty & flit_if.flit_out_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign enq       = flit_if.flit_in_valid & (~full | deq);
    assign drop      = flit_if.flit_in_valid & full & ~deq;
    assign bad       = ^flit_if.flit_in;

    // The start cycle only clears; flits seen then are never counted.
    assign cnt_en = enq & (state == S_RUN) & ~start;

    assign rx_next = (&rx_count) ? rx_count
                                 : rx_count + 31'd1;

    assign perr_next = (&parity_err_count)
                     ? parity_err_count
                     : parity_err_count + 1'b1;

    assign hit = cnt_en
               & (expected_num_flits != 31'd0)
               & (rx_next == expected_num_flits);

    assign flit_if.flit_out_valid = not_empty;
    assign flit_if.flit_out       = not_empty ? mem[rd_ptr] : '0;
    assign flit_if.credit_out     = credit_q;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[wr_ptr] <= flit_if.flit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            credit_q <= 1'b0;
        end else begin
            credit_q <= deq;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                enq & ~deq: occ <= occ + 1'b1;
                deq & ~enq: occ <= occ - 1'b1;
                default:    occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            rx_count         <= '0;
            parity_err_count <= '0;
            overflow_err     <= 1'b0;
        end else if (start) begin
            state            <= S_RUN;
            rx_count         <= '0;
            parity_err_count <= '0;
            overflow_err     <= 1'b0;
        end else begin
            if (drop) overflow_err <= 1'b1;
            if (cnt_en) begin
                rx_count <= rx_next;
                if (bad) parity_err_count <= perr_next;
            end
            if (hit) state <= S_DONE;
        end
    end

endmodule
